// File: rtl/ysyx_23060229_mc_ctrl.sv
// rtl/ysyx_23060229_mc_ctrl.sv - multi-cycle fetch/execute/memory sequencer for the NPC core
//
// Purpose:
//   Steps one instruction at a time through fetch, execute, optional data
//   memory access and write-back. Owns the PC and the instruction register.
//   Qualifies the decoder's register write so that each instruction commits
//   exactly once. Stops on ebreak (HALT), a bus timeout or a misaligned
//   next-PC (ERR). Both stop states are left only through reset.
//
// Ports:
//   clk, rst                     clock (rising edge), synchronous active-low reset
//   ifu_req_valid/ifu_req_ready  fetch request handshake, ifu_addr carries pc
//   ifu_rsp_valid/ifu_rdata      fetch response, latched into inst
//   inst, pc                     instruction register and PC to the datapath
//   is_mem, is_ebreak            IDU decode of inst (combinational)
//   reg_wen_dec                  IDU register-write request
//   next_pc                      EXU next-PC result
//   lsu_req_valid/lsu_req_ready  data memory request handshake
//   lsu_rsp_valid                data memory response / ack
//   reg_wen, retire              write-back strobes, high for one cycle in WB
//   retire_cnt                   committed-instruction count (wraps)
//   halted, err                  sticky stop indications

module ysyx_23060229_mc_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
    parameter int              TIMEOUT  = 255,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,

    output logic             ifu_req_valid,
    input  logic             ifu_req_ready,
    output logic [XLEN-1:0]  ifu_addr,
    input  logic             ifu_rsp_valid,
    input  logic [31:0]      ifu_rdata,

    output logic [31:0]      inst,
    output logic [XLEN-1:0]  pc,

    input  logic             is_mem,
    input  logic             is_ebreak,
    input  logic             reg_wen_dec,
    input  logic [XLEN-1:0]  next_pc,

    output logic             lsu_req_valid,
    input  logic             lsu_req_ready,
    input  logic             lsu_rsp_valid,

    output logic             reg_wen,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             halted,
    output logic             err
);

    // The timeout counter only has to count up to TIMEOUT-1.
    localparam int              TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_FETCH_REQ  = 3'd0,
        ST_FETCH_WAIT = 3'd1,
        ST_EXEC       = 3'd2,
        ST_MEM_REQ    = 3'd3,
        ST_MEM_WAIT   = 3'd4,
        ST_WB         = 3'd5,
        ST_HALT       = 3'd6,
        ST_ERR        = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  npc_q, npc_d;
    logic [31:0]      inst_q, inst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             bus_state;

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_FETCH_REQ;
            pc_q    <= RESET_PC;
            npc_q   <= RESET_PC;
            inst_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // States that wait on a bus handshake and are therefore subject to timeout.
    assign bus_state = (state_q == ST_FETCH_REQ)  || (state_q == ST_FETCH_WAIT) ||
                       (state_q == ST_MEM_REQ)    || (state_q == ST_MEM_WAIT);

    // Next-state and register update logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        npc_d   = npc_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        tmo_d   = '0;

        case (state_q)
            ST_FETCH_REQ: begin
                if (ifu_req_ready) begin
                    state_d = ST_FETCH_WAIT;
                end
            end
            ST_FETCH_WAIT: begin
                // Only a response seen here is taken; one that coincides
                // with the request cycle is dropped.
                if (ifu_rsp_valid) begin
                    inst_d  = ifu_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // ebreak wins over a misaligned next_pc.
                if (is_ebreak) begin
                    state_d = ST_HALT;
                end else if (next_pc[1:0] != 2'b00) begin
                    state_d = ST_ERR;
                end else begin
                    npc_d   = next_pc;
                    state_d = is_mem ? ST_MEM_REQ : ST_WB;
                end
            end
            ST_MEM_REQ: begin
                if (lsu_req_ready) begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (lsu_rsp_valid) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                pc_d    = npc_q;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = ST_FETCH_REQ;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_FETCH_REQ;
            end
        endcase

        // Stalled in a bus state: count the cycle, or give up after TIMEOUT
        // cycles. Any transition leaves tmo_d at its cleared default.
        if (bus_state && (state_d == state_q)) begin
            if (tmo_q == TMO_LAST) begin
                state_d = ST_ERR;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    // Moore outputs. Requests and strobes are also gated by rst so nothing
    // is driven while reset is held, whatever state it interrupted.
    assign ifu_req_valid = rst && (state_q == ST_FETCH_REQ);
    assign lsu_req_valid = rst && (state_q == ST_MEM_REQ);
    assign retire        = rst && (state_q == ST_WB);
    assign reg_wen       = retire && reg_wen_dec;
    assign ifu_addr      = pc_q;
    assign pc            = pc_q;
    assign inst          = inst_q;
    assign retire_cnt    = cnt_q;
    assign halted        = (state_q == ST_HALT);
    assign err           = (state_q == ST_ERR);

endmodule

// File: tb/tb_ysyx_23060229_mc_ctrl.sv
// tb/tb_ysyx_23060229_mc_ctrl.sv - directed self-checking bench for ysyx_23060229_mc_ctrl
module tb_ysyx_23060229_mc_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req_valid;
    logic        ifu_req_ready = 1'b0;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid = 1'b0;
    logic [31:0] ifu_rdata = 32'h0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        is_mem = 1'b0;
    logic        is_ebreak = 1'b0;
    logic        reg_wen_dec = 1'b0;
    logic [31:0] next_pc = 32'h0;
    logic        lsu_req_valid;
    logic        lsu_req_ready = 1'b0;
    logic        lsu_rsp_valid = 1'b0;
    logic        reg_wen;
    logic        retire;
    logic [1:0]  retire_cnt;
    logic        halted;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_pc;

    ysyx_23060229_mc_ctrl #(
        .XLEN     (32),
        .RESET_PC (RST_PC),
        .TIMEOUT  (8),
        .CNT_W    (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rdata     (ifu_rdata),
        .inst          (inst),
        .pc            (pc),
        .is_mem        (is_mem),
        .is_ebreak     (is_ebreak),
        .reg_wen_dec   (reg_wen_dec),
        .next_pc       (next_pc),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_rsp_valid (lsu_rsp_valid),
        .reg_wen       (reg_wen),
        .retire        (retire),
        .retire_cnt    (retire_cnt),
        .halted        (halted),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (ifu_req_valid !== 1'b0 || retire !== 1'b0 || reg_wen !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold: req=%b retire=%b wen=%b expected 0 0 0", ifu_req_valid, retire, reg_wen);
            end
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ifu_req_valid !== 1'b1) begin n_bad++; $display("FAIL reset_req: got %b expected 1", ifu_req_valid); end
        n_cmp++;
        if (pc !== RST_PC || ifu_addr !== RST_PC) begin n_bad++; $display("FAIL reset_pc: got %h/%h expected %h", pc, ifu_addr, RST_PC); end
        n_cmp++;
        if (retire_cnt !== 2'd0 || err !== 1'b0 || halted !== 1'b0 || inst !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_regs: cnt=%0d err=%b halted=%b inst=%h expected 0 0 0 0", retire_cnt, err, halted, inst);
        end
    endtask

    task automatic test_alu();
        ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b1; ifu_rdata = 32'h0010_0093;
        lsu_req_ready = 1'b1; lsu_rsp_valid = 1'b1;
        is_mem = 1'b0; is_ebreak = 1'b0; reg_wen_dec = 1'b1;
        exp_pc = RST_PC; next_pc = exp_pc + 32'd4;
        for (int i = 1; i <= 12; i++) begin
            tick();
            n_cmp++;
            if (retire !== (i % 4 == 3) || reg_wen !== (i % 4 == 3)) begin
                n_bad++;
                $display("FAIL alu_strobe tick %0d: retire=%b wen=%b expected %b", i, retire, reg_wen, (i % 4 == 3));
            end
            if (i == 2) begin
                n_cmp++;
                if (inst !== 32'h0010_0093) begin n_bad++; $display("FAIL alu_inst: got %h expected 00100093", inst); end
            end
            if (i % 4 == 3) begin
                n_cmp++;
                if (pc !== exp_pc) begin n_bad++; $display("FAIL alu_pc_wb tick %0d: got %h expected %h", i, pc, exp_pc); end
                exp_pc = exp_pc + 32'd4;
                next_pc = exp_pc + 32'd4;
            end
        end
        n_cmp++;
        if (pc !== 32'h8000_000C || retire_cnt !== 2'd3) begin
            n_bad++;
            $display("FAIL alu_end: pc=%h cnt=%0d expected 8000000c 3", pc, retire_cnt);
        end
    endtask

    task automatic test_load_backpressure();
        is_mem = 1'b1; lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b1;
        ifu_rsp_valid = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (lsu_req_valid !== 1'b0 || ifu_req_valid !== 1'b0 || retire !== 1'b0) begin
                n_bad++;
                $display("FAIL stray_rsp %0d: lsu_req=%b ifu_req=%b retire=%b expected 0 0 0", i, lsu_req_valid, ifu_req_valid, retire);
            end
        end
        lsu_rsp_valid = 1'b0; ifu_rsp_valid = 1'b1; ifu_rdata = 32'h0000_2003;
        tick();
        n_cmp++;
        if (inst !== 32'h0000_2003 || lsu_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL load_exec: inst=%h lsu_req=%b expected 00002003 0", inst, lsu_req_valid);
        end
        tick();
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (lsu_req_valid !== 1'b1 || reg_wen !== 1'b0) begin
                n_bad++;
                $display("FAIL load_memreq %0d: lsu_req=%b wen=%b expected 1 0", k, lsu_req_valid, reg_wen);
            end
            lsu_req_ready = (k == 5);
            tick();
        end
        lsu_req_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (lsu_req_valid !== 1'b0 || reg_wen !== 1'b0 || retire !== 1'b0) begin
                n_bad++;
                $display("FAIL load_memwait %0d: lsu_req=%b wen=%b retire=%b expected 0 0 0", k, lsu_req_valid, reg_wen, retire);
            end
            lsu_rsp_valid = (k == 1);
            tick();
        end
        lsu_rsp_valid = 1'b0;
        n_cmp++;
        if (retire !== 1'b1 || reg_wen !== 1'b1 || pc !== 32'h8000_000C) begin
            n_bad++;
            $display("FAIL load_wb: retire=%b wen=%b pc=%h expected 1 1 8000000c", retire, reg_wen, pc);
        end
        is_mem = 1'b0;
        exp_pc = 32'h8000_0010; next_pc = exp_pc + 32'd4;
        tick();
        n_cmp++;
        if (pc !== 32'h8000_0010 || retire_cnt !== 2'd0 || ifu_req_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL load_after: pc=%h cnt=%0d req=%b expected 80000010 0 1", pc, retire_cnt, ifu_req_valid);
        end
    endtask

    task automatic test_counter_wrap();
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i % 4 == 3) begin
                exp_pc = exp_pc + 32'd4;
                next_pc = exp_pc + 32'd4;
            end
        end
        n_cmp++;
        if (retire_cnt !== 2'd1 || pc !== 32'h8000_0024) begin
            n_bad++;
            $display("FAIL cnt_wrap: cnt=%0d pc=%h expected 1 80000024", retire_cnt, pc);
        end
    endtask

    task automatic test_mid_op_reset();
        is_mem = 1'b1; lsu_req_ready = 1'b1; lsu_rsp_valid = 1'b0;
        tick(); tick(); tick();
        n_cmp++;
        if (lsu_req_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_memreq: got %b expected 1", lsu_req_valid); end
        tick();
        n_cmp++;
        if (lsu_req_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_memwait: got %b expected 0", lsu_req_valid); end
        rst = 1'b0; lsu_rsp_valid = 1'b1;
        tick();
        n_cmp++;
        if (lsu_req_valid !== 1'b0 || ifu_req_valid !== 1'b0 || retire !== 1'b0 || reg_wen !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_hold: lsu=%b ifu=%b retire=%b wen=%b expected 0 0 0 0", lsu_req_valid, ifu_req_valid, retire, reg_wen);
        end
        rst = 1'b1; lsu_rsp_valid = 1'b0; is_mem = 1'b0;
        #1;
        n_cmp++;
        if (ifu_req_valid !== 1'b1 || lsu_req_valid !== 1'b0 || pc !== RST_PC || retire_cnt !== 2'd0) begin
            n_bad++;
            $display("FAIL midrst_release: ifu=%b lsu=%b pc=%h cnt=%0d expected 1 0 80000000 0", ifu_req_valid, lsu_req_valid, pc, retire_cnt);
        end
    endtask

    task automatic test_timeout();
        ifu_req_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) begin
                n_cmp++;
                if (ifu_req_valid !== 1'b1 || err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL tmo_before: req=%b err=%b expected 1 0", ifu_req_valid, err);
                end
            end
        end
        n_cmp++;
        if (err !== 1'b1 || ifu_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_err: err=%b req=%b expected 1 0", err, ifu_req_valid);
        end
        ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b1;
        tick(); tick(); tick();
        n_cmp++;
        if (err !== 1'b1 || ifu_req_valid !== 1'b0 || pc !== RST_PC || retire !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_sticky: err=%b req=%b pc=%h retire=%b expected 1 0 80000000 0", err, ifu_req_valid, pc, retire);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (err !== 1'b0 || ifu_req_valid !== 1'b1 || ifu_addr !== RST_PC) begin
            n_bad++;
            $display("FAIL tmo_recover: err=%b req=%b addr=%h expected 0 1 80000000", err, ifu_req_valid, ifu_addr);
        end
    endtask

    task automatic test_misaligned();
        is_mem = 1'b0; reg_wen_dec = 1'b1; next_pc = 32'h8000_0002;
        tick(); tick(); tick();
        n_cmp++;
        if (err !== 1'b1 || retire !== 1'b0 || reg_wen !== 1'b0) begin
            n_bad++;
            $display("FAIL misalign_err: err=%b retire=%b wen=%b expected 1 0 0", err, retire, reg_wen);
        end
        tick(); tick();
        n_cmp++;
        if (retire !== 1'b0 || retire_cnt !== 2'd0 || pc !== RST_PC || ifu_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL misalign_hold: retire=%b cnt=%0d pc=%h req=%b expected 0 0 80000000 0", retire, retire_cnt, pc, ifu_req_valid);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_halt();
        next_pc = 32'h8000_0004; is_ebreak = 1'b0;
        tick(); tick(); tick(); tick();
        ifu_rdata = 32'h0010_0073; is_ebreak = 1'b1; next_pc = 32'h8000_0008;
        tick(); tick(); tick();
        n_cmp++;
        if (halted !== 1'b1 || retire !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_enter: halted=%b retire=%b err=%b expected 1 0 0", halted, retire, err);
        end
        ifu_rdata = 32'hDEAD_BEEF;
        tick(); tick(); tick();
        n_cmp++;
        if (ifu_req_valid !== 1'b0 || lsu_req_valid !== 1'b0 || retire_cnt !== 2'd1 || pc !== 32'h8000_0004) begin
            n_bad++;
            $display("FAIL halt_frozen: ifu=%b lsu=%b cnt=%0d pc=%h expected 0 0 1 80000004", ifu_req_valid, lsu_req_valid, retire_cnt, pc);
        end
        n_cmp++;
        if (inst !== 32'h0010_0073 || halted !== 1'b1) begin
            n_bad++;
            $display("FAIL halt_inst: inst=%h halted=%b expected 00100073 1", inst, halted);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_backpressure();
        test_counter_wrap();
        test_mid_op_reset();
        test_timeout();
        test_misaligned();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
